// File: rtl/adc_meter_pkg.sv
// ============================================================================
// Module      : adc_meter_pkg
// Description : Shared types, widths and helpers for the ADC waveform meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_meter_pkg;

    localparam int unsigned c_sample_w = 8;
    localparam int unsigned c_cnt_w    = 32;
    localparam logic [c_sample_w-1:0] c_vmin_rst = '1;

    typedef enum logic [1:0] {
        ST_ARM    = 2'd0,
        ST_MEAS   = 2'd1,
        ST_REPORT = 2'd2
    } meter_state_t;

    // Saturating add so counters stick at all-ones instead of wrapping.
    function automatic logic [c_cnt_w-1:0] sat_add(input logic [c_cnt_w-1:0] a,
                                                   input logic [c_cnt_w-1:0] b);
        logic [c_cnt_w:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[c_cnt_w] ? '1 : s[c_cnt_w-1:0];
    endfunction

    function automatic logic [c_sample_w-1:0] thr_hi(input logic [c_sample_w-1:0] mid,
                                                     input logic [c_sample_w-1:0] hyst);
        logic [c_sample_w:0] s;
        s = {1'b0, mid} + {1'b0, hyst};
        return s[c_sample_w] ? '1 : s[c_sample_w-1:0];
    endfunction

    function automatic logic [c_sample_w-1:0] thr_lo(input logic [c_sample_w-1:0] mid,
                                                     input logic [c_sample_w-1:0] hyst);
        logic [c_sample_w:0] s;
        s = {1'b0, mid} - {1'b0, hyst};
        return s[c_sample_w] ? '0 : s[c_sample_w-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_level_detect.sv
// ============================================================================
// Module      : adc_level_detect
// Description : Hysteresis comparator on the registered sample; emits the
//               current level (only with DUTY_MEAS_EN) and a lo->hi pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_level_detect
    import adc_meter_pkg::*;
#(
    parameter logic [c_sample_w-1:0] MID_LEVEL = 8'd128,
    parameter logic [c_sample_w-1:0] HYST      = 8'd16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [c_sample_w-1:0] i_sample,
`ifdef DUTY_MEAS_EN
    output logic                  o_level,
`endif
    output logic                  o_rise
);

    localparam logic [c_sample_w-1:0] c_thr_hi = thr_hi(MID_LEVEL, HYST);
    localparam logic [c_sample_w-1:0] c_thr_lo = thr_lo(MID_LEVEL, HYST);

    logic level_q;
    logic level_d;

    // Between the thresholds the previous level is held.
    always_comb begin
        level_d = level_q;
        if (i_sample >= c_thr_hi) begin
            level_d = 1'b1;
        end else if (i_sample <= c_thr_lo) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign o_rise = level_d & ~level_q;

`ifdef DUTY_MEAS_EN
    assign o_level = level_d;
`endif

endmodule

`default_nettype wire

// File: rtl/adc_wave_meter.sv
// ============================================================================
// Module      : adc_wave_meter
// Description : Measures period sum, peak and trough of an ADC waveform over
//               N_PERIODS rising crossings. DUTY_MEAS_EN adds high-time sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_wave_meter
    import adc_meter_pkg::*;
#(
    parameter int unsigned          N_PERIODS = 4,
    parameter logic [c_sample_w-1:0] MID_LEVEL = 8'd128,
    parameter logic [c_sample_w-1:0] HYST      = 8'd16,
    parameter logic [c_cnt_w-1:0]    TIMEOUT   = 32'd50000000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [c_sample_w-1:0] adc_data,
    output logic                  adc_clk,
    output logic                  meas_valid,
    output logic                  meas_timeout,
    output logic [c_cnt_w-1:0]    period_sum,
    output logic [c_sample_w-1:0] vmax,
    output logic [c_sample_w-1:0] vmin,
    output logic [c_cnt_w-1:0]    high_sum
);

    localparam logic [7:0]         c_n_periods = 8'(N_PERIODS);
    localparam logic [c_cnt_w-1:0] c_one       = 32'd1;

    meter_state_t          state_q, state_d;
    logic [c_sample_w-1:0] s1_q;
    logic [c_cnt_w-1:0]    cnt_q, cnt_d;
    logic [c_cnt_w-1:0]    psum_q, psum_d;
    logic [7:0]            k_q, k_d;
    logic [c_sample_w-1:0] wmax_q, wmax_d, wmin_q, wmin_d;
    logic [c_cnt_w-1:0]    res_psum_q, res_psum_d;
    logic [c_sample_w-1:0] res_max_q, res_max_d, res_min_q, res_min_d;
    logic                  meas_valid_q, meas_valid_d;
    logic                  meas_timeout_q, meas_timeout_d;
    logic [c_cnt_w-1:0]    period_sum_q, period_sum_d;
    logic [c_sample_w-1:0] vmax_q, vmax_d, vmin_q, vmin_d;
    logic                  rise;
`ifdef DUTY_MEAS_EN
    logic                  level;
`endif

    assign adc_clk = ~sys_clk;

    adc_level_detect #(
        .MID_LEVEL (MID_LEVEL),
        .HYST      (HYST)
    ) u_level_detect (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .i_sample (s1_q),
`ifdef DUTY_MEAS_EN
        .o_level  (level),
`endif
        .o_rise   (rise)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        psum_d         = psum_q;
        k_d            = k_q;
        wmax_d         = wmax_q;
        wmin_d         = wmin_q;
        res_psum_d     = res_psum_q;
        res_max_d      = res_max_q;
        res_min_d      = res_min_q;
        meas_valid_d   = 1'b0;
        meas_timeout_d = meas_timeout_q;
        period_sum_d   = period_sum_q;
        vmax_d         = vmax_q;
        vmin_d         = vmin_q;

        case (state_q)
            ST_ARM: begin
                cnt_d = sat_add(cnt_q, c_one);
                if (rise) begin
                    cnt_d   = c_one;
                    psum_d  = '0;
                    k_d     = '0;
                    wmax_d  = s1_q;
                    wmin_d  = s1_q;
                    state_d = ST_MEAS;
                end else if (cnt_q >= TIMEOUT) begin
                    meas_valid_d = 1'b1;
                end
            end
            ST_MEAS: begin
                cnt_d  = sat_add(cnt_q, c_one);
                wmax_d = (s1_q > wmax_q) ? s1_q : wmax_q;
                wmin_d = (s1_q < wmin_q) ? s1_q : wmin_q;
                if (rise) begin
                    psum_d = sat_add(psum_q, cnt_q);
                    cnt_d  = c_one;
                    k_d    = k_q + 8'd1;
                    // The Nth crossing closes this window and opens the next.
                    if (k_q + 8'd1 == c_n_periods) begin
                        res_psum_d = sat_add(psum_q, cnt_q);
                        res_max_d  = wmax_q;
                        res_min_d  = wmin_q;
                        psum_d     = '0;
                        k_d        = '0;
                        wmax_d     = s1_q;
                        wmin_d     = s1_q;
                        state_d    = ST_REPORT;
                    end
                end else if (cnt_q >= TIMEOUT) begin
                    meas_valid_d = 1'b1;
                end
            end
            ST_REPORT: begin
                cnt_d          = sat_add(cnt_q, c_one);
                wmax_d         = (s1_q > wmax_q) ? s1_q : wmax_q;
                wmin_d         = (s1_q < wmin_q) ? s1_q : wmin_q;
                meas_valid_d   = 1'b1;
                meas_timeout_d = 1'b0;
                period_sum_d   = res_psum_q;
                vmax_d         = res_max_q;
                vmin_d         = res_min_q;
                state_d        = ST_MEAS;
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase

        // Timeout result: window extremes so far, then re-arm.
        if (meas_valid_d && (state_q != ST_REPORT)) begin
            meas_timeout_d = 1'b1;
            period_sum_d   = '0;
            vmax_d         = wmax_q;
            vmin_d         = wmin_q;
            wmax_d         = '0;
            wmin_d         = c_vmin_rst;
            cnt_d          = c_one;
            state_d        = ST_ARM;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q        <= ST_ARM;
            s1_q           <= '0;
            cnt_q          <= '0;
            psum_q         <= '0;
            k_q            <= '0;
            wmax_q         <= '0;
            wmin_q         <= c_vmin_rst;
            res_psum_q     <= '0;
            res_max_q      <= '0;
            res_min_q      <= c_vmin_rst;
            meas_valid_q   <= 1'b0;
            meas_timeout_q <= 1'b0;
            period_sum_q   <= '0;
            vmax_q         <= '0;
            vmin_q         <= c_vmin_rst;
        end else begin
            state_q        <= state_d;
            s1_q           <= adc_data;
            cnt_q          <= cnt_d;
            psum_q         <= psum_d;
            k_q            <= k_d;
            wmax_q         <= wmax_d;
            wmin_q         <= wmin_d;
            res_psum_q     <= res_psum_d;
            res_max_q      <= res_max_d;
            res_min_q      <= res_min_d;
            meas_valid_q   <= meas_valid_d;
            meas_timeout_q <= meas_timeout_d;
            period_sum_q   <= period_sum_d;
            vmax_q         <= vmax_d;
            vmin_q         <= vmin_d;
        end
    end

    assign meas_valid   = meas_valid_q;
    assign meas_timeout = meas_timeout_q;
    assign period_sum   = period_sum_q;
    assign vmax         = vmax_q;
    assign vmin         = vmin_q;

`ifdef DUTY_MEAS_EN
    logic               rpt_cycle, win_end, win_start, to_fire;
    logic [c_cnt_w-1:0] hcnt_q, hcnt_d, hres_q, hres_d, high_sum_q, high_sum_d;

    assign rpt_cycle = (state_q == ST_REPORT);
    assign win_end   = (state_q == ST_MEAS) && (state_d == ST_REPORT);
    assign win_start = ((state_q == ST_ARM) && (state_d == ST_MEAS)) || win_end;
    assign to_fire   = meas_valid_d && !rpt_cycle;

    // High-time follows the same window boundaries as the period counter.
    always_comb begin
        hcnt_d     = sat_add(hcnt_q, {{(c_cnt_w-1){1'b0}}, level});
        hres_d     = hres_q;
        high_sum_d = high_sum_q;
        if (win_end) begin
            hres_d = hcnt_q;
        end
        if (win_start) begin
            hcnt_d = {{(c_cnt_w-1){1'b0}}, level};
        end
        if (rpt_cycle) begin
            high_sum_d = hres_q;
        end else if (to_fire) begin
            high_sum_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hcnt_q     <= '0;
            hres_q     <= '0;
            high_sum_q <= '0;
        end else begin
            hcnt_q     <= hcnt_d;
            hres_q     <= hres_d;
            high_sum_q <= high_sum_d;
        end
    end

    assign high_sum = high_sum_q;
`else
    assign high_sum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adc_wave_meter.sv
// ============================================================================
// Module      : tb_adc_wave_meter
// Description : Directed scoreboard bench for adc_wave_meter (N=4, TIMEOUT=1000).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_wave_meter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  adc_data = 8'd0;
    logic        adc_clk;
    logic        meas_valid;
    logic        meas_timeout;
    logic [31:0] period_sum;
    logic [7:0]  vmax;
    logic [7:0]  vmin;
    logic [31:0] high_sum;

    adc_wave_meter #(
        .N_PERIODS (4),
        .MID_LEVEL (8'd128),
        .HYST      (8'd16),
        .TIMEOUT   (32'd1000)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .adc_data     (adc_data),
        .adc_clk      (adc_clk),
        .meas_valid   (meas_valid),
        .meas_timeout (meas_timeout),
        .period_sum   (period_sum),
        .vmax         (vmax),
        .vmin         (vmin),
        .high_sum     (high_sum)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        to;
        logic [31:0] ps;
        logic [31:0] hs;
        logic [7:0]  mx;
        logic [7:0]  mn;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rst_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hs_exp(input int x);
`ifdef DUTY_MEAS_EN
        return 32'(x);
`else
        return (x > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic push(input int due, input logic to, input logic [31:0] ps,
                        input logic [31:0] hs, input logic [7:0] mx, input logic [7:0] mn);
        exp_t e;
        e.due = due; e.to = to; e.ps = ps; e.hs = hs; e.mx = mx; e.mn = mn;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: compares every result pulse against the oldest expectation.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (meas_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", {31'd0, meas_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("valid_cycle", 32'(cyc), 32'(e.due));
                    chk("meas_timeout", {31'd0, meas_timeout}, {31'd0, e.to});
                    chk("period_sum", period_sum, e.ps);
                    chk("high_sum", high_sum, e.hs);
                    chk("vmax", {24'd0, vmax}, {24'd0, e.mx});
                    chk("vmin", {24'd0, vmin}, {24'd0, e.mn});
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                chk("missing_valid", {31'd0, meas_valid}, 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input logic [7:0] v);
        adc_data = v;
        @(negedge sys_clk);
    endtask

    task automatic do_reset(input logic [7:0] v);
        chk("sb_empty_before_reset", 32'(sb.size()), 32'd0);
        adc_data = v;
        sys_rst  = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("rst_meas_valid", {31'd0, meas_valid}, 32'd0);
        chk("rst_meas_timeout", {31'd0, meas_timeout}, 32'd0);
        chk("rst_period_sum", period_sum, 32'd0);
        chk("rst_high_sum", high_sum, 32'd0);
        chk("rst_vmax", {24'd0, vmax}, 32'd0);
        chk("rst_vmin", {24'd0, vmin}, 32'd255);
        sys_rst = 1'b0;
        rst_cyc = cyc;
    endtask

    // Square wave starting with the high phase; a result is expected on the
    // crossing that starts period 'first' and every fourth period after it.
    task automatic square(input int periods, input int hi, input int lo,
                          input logic [7:0] vh, input logic [7:0] vl, input int first,
                          input logic [31:0] ps, input logic [31:0] hs,
                          input logic [7:0] mx, input logic [7:0] mn);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < hi + lo; i++) begin
                if (i == 0 && p >= first && ((p - first) % 4) == 0)
                    push(cyc + 3, 1'b0, ps, hs, mx, mn);
                drive((i < hi) ? vh : vl);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge sys_clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        @(negedge sys_clk);
        do_reset(8'd0);
        chk("adc_clk_low_phase", {31'd0, adc_clk}, 32'd1);
        @(posedge sys_clk); #1;
        chk("adc_clk_high_phase", {31'd0, adc_clk}, 32'd0);
        @(negedge sys_clk);

        // Square 0/255 period 100: back-to-back windows of 400 cycles.
        square(13, 50, 50, 8'd255, 8'd0, 4, 32'd400, hs_exp(200), 8'd255, 8'd0);

        // Reset part-way through a window; next result needs a full new window.
        for (int i = 0; i < 50; i++) drive(8'd255);
        for (int i = 0; i < 20; i++) drive(8'd0);
        do_reset(8'd0);
        for (int i = 0; i < 30; i++) drive(8'd0);
        square(5, 50, 50, 8'd255, 8'd0, 4, 32'd400, hs_exp(200), 8'd255, 8'd0);
        drain();

        // Duty 30/70.
        do_reset(8'd0);
        square(5, 30, 70, 8'd255, 8'd0, 4, 32'd400, hs_exp(120), 8'd255, 8'd0);
        drain();

        // Sawtooth 0..255: crossing at 144 each period, 112 high samples per period.
        do_reset(8'd0);
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 256; i++) begin
                if (i == 144 && p == 4)
                    push(cyc + 3, 1'b0, 32'd1024, hs_exp(448), 8'd255, 8'd0);
                drive(8'(i));
            end
        end
        drain();

        // Constant mid level: timeouts from ARM every 1000 cycles.
        do_reset(8'd128);
        push(rst_cyc + 1001, 1'b1, 32'd0, 32'd0, 8'd0, 8'd255);
        push(rst_cyc + 2001, 1'b1, 32'd0, 32'd0, 8'd0, 8'd255);
        for (int i = 0; i < 2050; i++) drive(8'd128);
        drain();

        // Square inside the hysteresis band never crosses.
        do_reset(8'd120);
        push(rst_cyc + 1001, 1'b1, 32'd0, 32'd0, 8'd0, 8'd255);
        push(rst_cyc + 2001, 1'b1, 32'd0, 32'd0, 8'd0, 8'd255);
        square(41, 25, 25, 8'd136, 8'd120, 1000, 32'd0, 32'd0, 8'd0, 8'd0);
        drain();

        // Single crossing then flat: timeout from MEAS with window extremes,
        // then a normal result must clear meas_timeout.
        do_reset(8'd0);
        push(cyc + 1002, 1'b1, 32'd0, 32'd0, 8'd255, 8'd128);
        for (int i = 0; i < 10; i++) drive(8'd255);
        for (int i = 0; i < 1040; i++) drive(8'd128);
        square(6, 50, 50, 8'd255, 8'd0, 5, 32'd400, hs_exp(200), 8'd255, 8'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
